rx_frame_checker: RTL

Byte-stream sink that sits after `Rx` on the receive path and checks each recovered frame against the known test-frame format that `Tx` transmits. It consumes the `data_tdata/tvalid/tlast/tuser` stream at 1.024 MHz. It validates the sync byte, sequence continuity, payload pattern and frame length. Per-frame pass/fail pulses and saturating statistics counters drive ILA/BER measurement.

---
 rtl/rx_frame_checker.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_checker.sv
// Receive-side test-frame checker: validates sync, sequence continuity, payload pattern
// and length of each frame, and keeps saturating statistics for BER measurement.
//
// state   | meaning
// IDLE    | waiting for a tuser-marked header byte
// SEQ     | header seen, next valid beat is the sequence number
// PAYLOAD | comparing payload bytes against seq + idx
// DRAIN   | frame overran its length; discard until tlast
module rx_frame_checker #(
  parameter int          FRAME_LEN = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'h7E
) (
  input  logic        clk_1M024,
  input  logic        rst_n_1M024,
  input  logic        clear,
  input  logic [7:0]  data_tdata,
  input  logic        data_tvalid,
  input  logic        data_tuser,
  input  logic        data_tlast,
  output logic        frame_done,
  output logic        frame_pass,
  output logic        locked,
  output logic [7:0]  last_seq,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt,
  output logic [15:0] byte_err_cnt,
  output logic [15:0] seq_gap_cnt
);

  typedef enum logic [1:0] {IDLE, SEQ, PAYLOAD, DRAIN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_idx, w_idx_nxt;
  logic [7:0] r_seq, w_seq_nxt;
  logic       r_hdr_err, w_hdr_err_nxt;
  logic       r_byte_err, w_byte_err_nxt;
  logic       r_len_err, w_len_err_nxt;
  logic       r_gap, w_gap_nxt;
  logic       w_close_a, w_pass_a, w_gap_a, w_seq_upd_a;
  logic [7:0] w_seq_a;
  logic       w_close_b;
  logic       w_byte_mis;
  logic [7:0] w_exp;
  logic [1:0] r_q_cnt;
  logic [1:0] r_q_pass;
  logic [3:0] w_q_all;
  logic [2:0] w_q_cnt;
  logic       w_emit, w_emit_pass;
  logic       w_ok_inc, w_gap_inc;
  logic [1:0] w_err_inc;

  assign w_exp = r_seq + r_idx;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // close_a is the frame being closed (normal, length or abort); close_b only occurs
  // when an aborting beat also carries tlast and thus closes its own new header.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_seq_nxt      = r_seq;
    w_hdr_err_nxt  = r_hdr_err;
    w_byte_err_nxt = r_byte_err;
    w_len_err_nxt  = r_len_err;
    w_gap_nxt      = r_gap;
    w_close_a      = 1'b0;
    w_pass_a       = 1'b0;
    w_gap_a        = 1'b0;
    w_seq_upd_a    = 1'b0;
    w_seq_a        = r_seq;
    w_close_b      = 1'b0;
    w_byte_mis     = 1'b0;
    if (data_tvalid) begin
      if (data_tuser) begin
        if (r_state != IDLE) begin
          w_close_a   = 1'b1;
          w_gap_a     = r_gap;
          w_seq_upd_a = (r_state == PAYLOAD) || (r_state == DRAIN);
        end
        w_hdr_err_nxt  = (data_tdata != SYNC_BYTE);
        w_byte_err_nxt = 1'b0;
        w_len_err_nxt  = 1'b0;
        w_gap_nxt      = 1'b0;
        w_seq_nxt      = 8'd0;
        w_idx_nxt      = 8'd0;
        if (data_tlast) begin
          if (r_state != IDLE) w_close_b = 1'b1;
          else                 w_close_a = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SEQ;
        end
      end else begin
        case (r_state)
          SEQ: begin
            w_seq_nxt = data_tdata;
            w_gap_nxt = locked && (data_tdata != last_seq + 8'd1);
            w_idx_nxt = 8'd0;
            if (data_tlast) begin
              w_close_a   = 1'b1;
              w_gap_a     = w_gap_nxt;
              w_seq_upd_a = 1'b1;
              w_seq_a     = data_tdata;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = PAYLOAD;
            end
          end
          PAYLOAD: begin
            w_byte_mis     = (data_tdata != w_exp);
            w_byte_err_nxt = r_byte_err | w_byte_mis;
            if (data_tlast) begin
              w_close_a   = 1'b1;
              w_gap_a     = r_gap;
              w_seq_upd_a = 1'b1;
              w_pass_a    = (r_idx == LAST_IDX) && !r_hdr_err && !w_byte_err_nxt &&
                            !r_len_err && !r_gap;
              w_state_nxt = IDLE;
            end else if (r_idx == LAST_IDX) begin
              w_len_err_nxt = 1'b1;
              w_state_nxt   = DRAIN;
            end else begin
              w_idx_nxt = r_idx + 8'd1;
            end
          end
          DRAIN: begin
            if (data_tlast) begin
              w_close_a   = 1'b1;
              w_gap_a     = r_gap;
              w_seq_upd_a = 1'b1;
              w_state_nxt = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pending-pulse queue keeps frame_done from being high on adjacent cycles; statistics
  // are never deferred, and pulses beyond the queue depth are dropped.
  always_comb begin
    w_q_all = {2'b00, r_q_pass};
    w_q_cnt = {1'b0, r_q_cnt};
    if (w_close_a) begin
      w_q_all[w_q_cnt[1:0]] = w_pass_a;
      w_q_cnt = w_q_cnt + 3'd1;
    end
    if (w_close_b) begin
      w_q_all[w_q_cnt[1:0]] = 1'b0;
      w_q_cnt = w_q_cnt + 3'd1;
    end
    w_emit      = !frame_done && (w_q_cnt != 3'd0);
    w_emit_pass = w_q_all[0];
    if (w_emit) begin
      w_q_all = w_q_all >> 1;
      w_q_cnt = w_q_cnt - 3'd1;
    end
  end

  assign w_ok_inc  = w_close_a && w_pass_a;
  assign w_gap_inc = w_close_a && w_gap_a;
  assign w_err_inc = {1'b0, w_close_a && !w_pass_a} + {1'b0, w_close_b};

  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      r_state       <= IDLE;
      r_idx         <= 8'd0;
      r_seq         <= 8'd0;
      r_hdr_err     <= 1'b0;
      r_byte_err    <= 1'b0;
      r_len_err     <= 1'b0;
      r_gap         <= 1'b0;
      r_q_cnt       <= 2'd0;
      r_q_pass      <= 2'd0;
      frame_done    <= 1'b0;
      frame_pass    <= 1'b0;
      locked        <= 1'b0;
      last_seq      <= 8'd0;
      frame_ok_cnt  <= 16'd0;
      frame_err_cnt <= 16'd0;
      byte_err_cnt  <= 16'd0;
      seq_gap_cnt   <= 16'd0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_idx         <= 8'd0;
      r_seq         <= 8'd0;
      r_hdr_err     <= 1'b0;
      r_byte_err    <= 1'b0;
      r_len_err     <= 1'b0;
      r_gap         <= 1'b0;
      r_q_cnt       <= 2'd0;
      r_q_pass      <= 2'd0;
      frame_done    <= 1'b0;
      frame_pass    <= 1'b0;
      locked        <= 1'b0;
      frame_ok_cnt  <= 16'd0;
      frame_err_cnt <= 16'd0;
      byte_err_cnt  <= 16'd0;
      seq_gap_cnt   <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_seq         <= w_seq_nxt;
      r_hdr_err     <= w_hdr_err_nxt;
      r_byte_err    <= w_byte_err_nxt;
      r_len_err     <= w_len_err_nxt;
      r_gap         <= w_gap_nxt;
      r_q_cnt       <= (w_q_cnt > 3'd2) ? 2'd2 : w_q_cnt[1:0];
      r_q_pass      <= w_q_all[1:0];
      frame_done    <= w_emit;
      frame_pass    <= w_emit && w_emit_pass;
      if (w_ok_inc)    locked   <= 1'b1;
      if (w_seq_upd_a) last_seq <= w_seq_a;
      frame_ok_cnt  <= sat_add(frame_ok_cnt, {1'b0, w_ok_inc});
      frame_err_cnt <= sat_add(frame_err_cnt, w_err_inc);
      byte_err_cnt  <= sat_add(byte_err_cnt, {1'b0, w_byte_mis});
      seq_gap_cnt   <= sat_add(seq_gap_cnt, {1'b0, w_gap_inc});
    end
  end

endmodule
